serial_paralelo: RTL and testbench
==================================

# serial_paralelo

Serial-to-parallel front end of the receive path. It deserialises a single MSB-first bit stream into bytes and locks onto the stream after a run of idle characters (0xBC). Once locked, it presents each non-idle byte with a valid flag to the first demux layer, which splits the byte stream toward DEMUXL1.

## Interface
- IDLE, 8'hBC, idle/comma character; never delivered as data.
- SYNC_COUNT, 4, number of consecutive aligned IDLE bytes required to declare lock.
- clk_32f  input  1  bit clock; one serial bit is sampled per rising edge.
- reset_L  input  1  asynchronous, active-low reset; one clock domain only.
- data_in  input  1  serial data, MSB of each byte first.
- data_out  output  8  deserialised byte; updated only at byte boundaries.
- valid_out  output  1  high for the 8 cycles a non-IDLE byte is presented while locked.
- active  output  1  lock indicator; high once SYNC_COUNT consecutive IDLE bytes have been seen.

## Operation
- Byte alignment is fixed by reset: the first rising edge after reset_L deasserts samples bit 7 of byte 0. No bit-slip search is performed.
- Internals:
  - 7-bit shift register.
  - 3-bit bit counter bit_cnt, 0..7, wrapping 7→0.
  - Saturating IDLE counter idle_cnt, wide enough for SYNC_COUNT.
- Each edge: shift register ← {shift[5:0], data_in}; bit_cnt ← bit_cnt+1.
- At bit_cnt==7, byte = {shift[6:0], data_in}. This is the byte boundary; all decisions below are made on it.
- State machine with two states, SEARCH and ACTIVE:
  - SEARCH (reset state):
    - byte==IDLE → idle_cnt+1.
    - Any other byte → idle_cnt←0.
    - When the increment makes idle_cnt reach SYNC_COUNT → ACTIVE, and active←1 on that same edge.
    - valid_out=0 throughout; data_out holds its last value (0 after reset).
  - ACTIVE:
    - byte==IDLE → valid_out←0, data_out holds.
    - byte!=IDLE → data_out←byte, valid_out←1.
    - ACTIVE is exited only by reset; errors do not drop lock.
- Non-IDLE bytes arriving before lock are discarded.

## Timing
- Reset values, applied asynchronously while reset_L=0: data_out=8'h00, valid_out=0, active=0, state=SEARCH, bit_cnt=0, idle_cnt=0, shift=0.
- All outputs are registered and change only on the bit_cnt==7 edge. Between boundaries they are stable for exactly 8 clk_32f cycles.
- Latency: the last bit (LSB) of a byte is sampled on edge k; data_out/valid_out reflect that byte immediately after edge k.
- active rises after the edge that samples the LSB of the SYNC_COUNT-th consecutive IDLE. From reset release, the earliest possible rise is edge 8·SYNC_COUNT (edge 32 by default).
- The first data byte after lock can appear at the very next boundary. There is no dead byte.
- idle_cnt saturates at SYNC_COUNT. In ACTIVE it is don't-care.
- Reset mid-byte or mid-lock: everything clears immediately. After release, the partial byte is lost and alignment restarts from the next edge. The upstream transmitter is reset in the same cycle, so it realigns with it.
- Back-to-back data bytes: valid_out stays high continuously, and data_out changes every 8 cycles.
- IDLE between data: valid_out low for exactly 8 cycles per IDLE byte.

## Test plan
- Reset, then 4×0xBC, then 0xFF: active=0 through edge 31 and 1 right after edge 32. data_out=0xFF with valid_out=1 after edge 40.
- 3×0xBC, 0x55, 4×0xBC, 0xAA: idle_cnt restarts at 0x55 and 0x55 is never presented. active rises after edge 64. data_out=0xAA, valid=1 after edge 72.
- Locked stream 0xFF,0xEE,0xBC,0xDD: valid_out pattern is 1,1,0,1. data_out reads 0xFF,0xEE,0xEE (held),0xDD.
- Locked stream of 8 random non-IDLE bytes: each byte appears unchanged, in order, one byte per 8 cycles. valid_out stays high continuously.
- Locked stream, reset_L pulsed low at bit 3 of a data byte: outputs are 0/0/0 immediately. After release, 4×0xBC are required again before any valid_out.
- Stream of 0xBD (one bit off IDLE) repeated 10 times: active never rises and valid_out stays 0.

Source files
------------

// File: rtl/serial_paralelo_if.sv
// Serial receive front-end bundle: one serial bit in, deserialised byte plus
// valid/lock indications out.
interface serial_paralelo_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );
endinterface

// File: rtl/serial_paralelo.sv
// MSB-first serial-to-parallel converter with idle-character lock detection.
// state  | meaning
// SEARCH | counting consecutive aligned IDLE bytes, all bytes discarded
// ACTIVE | locked; non-IDLE bytes presented with valid_out
module serial_paralelo #(
    parameter logic [7:0] IDLE       = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    serial_paralelo_if.slave  bus
);

    localparam int IDLE_W = $clog2(SYNC_COUNT + 1);

    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [6:0]        shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic              active_q, active_d;
    logic [7:0]        byte_w;

    assign byte_w = {shift_q, bus.data_in};

    always_comb begin
        state_d     = state_q;
        shift_d     = {shift_q[5:0], bus.data_in};
        bit_cnt_d   = bit_cnt_q + 3'd1;
        idle_cnt_d  = idle_cnt_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        active_d    = active_q;

        if (bit_cnt_q == 3'd7) begin
            case (state_q)
                SEARCH: begin
                    valid_out_d = 1'b0;
                    if (byte_w == IDLE) begin
                        if (idle_cnt_q < IDLE_W'(SYNC_COUNT))
                            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                        // The increment reaching SYNC_COUNT locks on this same edge.
                        if (idle_cnt_q == IDLE_W'(SYNC_COUNT - 1)) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        idle_cnt_d = '0;
                    end
                end
                default: begin
                    if (byte_w == IDLE) begin
                        valid_out_d = 1'b0;
                    end else begin
                        data_out_d  = byte_w;
                        valid_out_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= SEARCH;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            active_q    <= active_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.active    = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: byte-level reference model compared every
// cycle, plus literal expectations at the key boundaries.
module tb_serial_paralelo;

    logic clk_32f = 1'b0;
    logic reset_L = 1'b0;

    serial_paralelo_if bus ();

    serial_paralelo dut (
        .clk_32f (clk_32f),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    always #5 clk_32f = ~clk_32f;

    int checks = 0;
    int errors = 0;

    // Byte-level model: alignment is implicit in sending whole bytes.
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_active;
    int         m_run;
    int         edge_cnt;

    always @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_active = 1'b0;
        m_run    = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_active) begin
            m_valid = 1'b0;
            m_run   = (b == 8'hBC) ? m_run + 1 : 0;
            if (m_run >= 4) m_active = 1'b1;
        end else if (b == 8'hBC) begin
            m_valid = 1'b0;
        end else begin
            m_data  = b;
            m_valid = 1'b1;
        end
    endtask

    logic cmp_en = 1'b0;
    always @(negedge clk_32f) begin
        if (cmp_en) begin
            check("cyc_data",   {24'h0, bus.data_out}, {24'h0, m_data});
            check("cyc_valid",  {31'h0, bus.valid_out}, {31'h0, m_valid});
            check("cyc_active", {31'h0, bus.active},    {31'h0, m_active});
        end
    end

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk_32f);
            bus.data_in = b[i];
        end
        @(posedge clk_32f);
        #1;
        model_byte(b);
    endtask

    // Release lands just after an edge so the next edge samples bit 7 of byte 0.
    task automatic do_reset();
        @(posedge clk_32f);
        #1;
        reset_L = 1'b0;
        model_clear();
        repeat (3) @(posedge clk_32f);
        #1;
        reset_L = 1'b1;
    endtask

    logic [7:0] rb;

    initial begin
        bus.data_in = 1'b0;
        model_clear();
        cmp_en = 1'b1;
        do_reset();

        // Lock after 4 idles, first data at the next boundary
        check("rst_data",   {24'h0, bus.data_out}, 32'h0);
        check("rst_valid",  {31'h0, bus.valid_out}, 32'h0);
        check("rst_active", {31'h0, bus.active},    32'h0);
        repeat (3) send_byte(8'hBC);
        check("t1_active_e24", {31'h0, bus.active}, 32'h0);
        send_byte(8'hBC);
        check("t1_lock_edge",  edge_cnt, 32);
        check("t1_active_e32", {31'h0, bus.active}, 32'h1);
        check("t1_valid_e32",  {31'h0, bus.valid_out}, 32'h0);
        send_byte(8'hFF);
        check("t1_edge40",  edge_cnt, 40);
        check("t1_data_ff", {24'h0, bus.data_out}, 32'hFF);
        check("t1_valid_ff",{31'h0, bus.valid_out}, 32'h1);

        // Broken idle run restarts the count; pre-lock data discarded
        do_reset();
        repeat (3) send_byte(8'hBC);
        send_byte(8'h55);
        check("t2_active_55", {31'h0, bus.active}, 32'h0);
        check("t2_data_55",   {24'h0, bus.data_out}, 32'h0);
        repeat (3) send_byte(8'hBC);
        check("t2_active_e56", {31'h0, bus.active}, 32'h0);
        send_byte(8'hBC);
        check("t2_lock_edge", edge_cnt, 64);
        check("t2_active",    {31'h0, bus.active}, 32'h1);
        send_byte(8'hAA);
        check("t2_edge72",  edge_cnt, 72);
        check("t2_data_aa", {24'h0, bus.data_out}, 32'hAA);
        check("t2_valid_aa",{31'h0, bus.valid_out}, 32'h1);

        // Idle between data drops valid, holds data
        send_byte(8'hFF);
        check("t3_d0", {24'h0, bus.data_out}, 32'hFF); check("t3_v0", {31'h0, bus.valid_out}, 32'h1);
        send_byte(8'hEE);
        check("t3_d1", {24'h0, bus.data_out}, 32'hEE); check("t3_v1", {31'h0, bus.valid_out}, 32'h1);
        send_byte(8'hBC);
        check("t3_d2", {24'h0, bus.data_out}, 32'hEE); check("t3_v2", {31'h0, bus.valid_out}, 32'h0);
        send_byte(8'hDD);
        check("t3_d3", {24'h0, bus.data_out}, 32'hDD); check("t3_v3", {31'h0, bus.valid_out}, 32'h1);

        // Back-to-back random non-idle bytes
        for (int n = 0; n < 8; n++) begin
            rb = 8'($urandom_range(0, 255));
            if (rb == 8'hBC) rb = 8'h3C;
            send_byte(rb);
            check("t4_data", {24'h0, bus.data_out}, {24'h0, rb});
        end

        // Reset in the middle of a data byte
        for (int i = 7; i >= 4; i--) begin
            @(negedge clk_32f);
            bus.data_in = rb[i];
        end
        @(posedge clk_32f);
        #1;
        reset_L = 1'b0;
        #1;
        check("t5_rst_data",   {24'h0, bus.data_out}, 32'h0);
        check("t5_rst_valid",  {31'h0, bus.valid_out}, 32'h0);
        check("t5_rst_active", {31'h0, bus.active},    32'h0);
        model_clear();
        repeat (2) @(posedge clk_32f);
        #1;
        reset_L = 1'b1;
        repeat (3) send_byte(8'hBC);
        send_byte(8'h12);
        check("t5_prelock_valid", {31'h0, bus.valid_out}, 32'h0);
        repeat (4) send_byte(8'hBC);
        send_byte(8'h12);
        check("t5_relock_data",  {24'h0, bus.data_out}, 32'h12);
        check("t5_relock_valid", {31'h0, bus.valid_out}, 32'h1);

        // Near-idle character never locks
        do_reset();
        repeat (10) send_byte(8'hBD);
        check("t6_active", {31'h0, bus.active},    32'h0);
        check("t6_valid",  {31'h0, bus.valid_out}, 32'h0);

        @(negedge clk_32f);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
